// File: rtl/wts_mem_arb_pkg.sv
// Shared types and default timing for the wave-table cartridge memory arbiter.
package wts_mem_arb_pkg;

    localparam int ADDR_W_DEF         = 21;
    localparam int ACCESS_CYCLES_DEF  = 3;
    localparam int RECOVER_CYCLES_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_CPU_HOLD,
        ST_WAVE_ACC,
        ST_RECOVER
    } arb_state_t;

    function automatic int max_u(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wts_mem_access_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module wts_mem_access_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/wts_mem_arbiter.sv
// Arbitrates the external cartridge memory between CPU reads (priority) and wave fetches.
module wts_mem_arbiter
    import wts_mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int ACCESS_CYCLES  = ACCESS_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              slot_nreset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_valid,
    input  logic              wave_req,
    input  logic [ADDR_W-1:0] wave_address,
    output logic              wave_ack,
    output logic [7:0]        wave_rdata,
    output logic              wave_valid,
    output logic              mem_ncs,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_d
);

    localparam int TMR_W = $clog2(max_u(ACCESS_CYCLES, RECOVER_CYCLES) + 1);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_value;
    logic             w_tmr_done;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (cpu_req)       w_next = ST_CPU_ACC;
                else if (wave_req) w_next = ST_WAVE_ACC;
            end
            ST_CPU_ACC: begin
                if (!cpu_req)        w_next = ST_RECOVER;
                else if (w_tmr_done) w_next = ST_CPU_HOLD;
            end
            ST_CPU_HOLD: begin
                if (!cpu_req) w_next = ST_RECOVER;
            end
            ST_WAVE_ACC: begin
                if (w_tmr_done) w_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (w_tmr_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Timer reloads on every state change; the load value is one less than the phase
    // length because done is judged from the registered count on the following edges.
    always_comb begin
        w_tmr_load  = (w_next != r_state);
        w_tmr_value = '0;
        if (w_next == ST_CPU_ACC || w_next == ST_WAVE_ACC)
            w_tmr_value = TMR_W'(ACCESS_CYCLES - 1);
        else if (w_next == ST_RECOVER)
            w_tmr_value = TMR_W'(RECOVER_CYCLES - 1);
    end

    wts_mem_access_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (slot_nreset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            r_state    <= ST_IDLE;
            mem_ncs    <= 1'b1;
            mem_a      <= '0;
            cpu_rdata  <= '0;
            cpu_valid  <= 1'b0;
            wave_ack   <= 1'b0;
            wave_rdata <= '0;
            wave_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            cpu_valid  <= 1'b0;
            wave_ack   <= 1'b0;
            wave_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        mem_a   <= cpu_address;
                        mem_ncs <= 1'b0;
                    end else if (wave_req) begin
                        mem_a    <= wave_address;
                        mem_ncs  <= 1'b0;
                        wave_ack <= 1'b1;
                    end
                end
                ST_CPU_ACC: begin
                    if (!cpu_req) begin
                        mem_ncs <= 1'b1;
                    end else if (w_tmr_done) begin
                        cpu_rdata <= mem_d;
                        cpu_valid <= 1'b1;
                    end
                end
                ST_CPU_HOLD: begin
                    if (!cpu_req) mem_ncs <= 1'b1;
                end
                ST_WAVE_ACC: begin
                    if (w_tmr_done) begin
                        wave_rdata <= mem_d;
                        wave_valid <= 1'b1;
                        mem_ncs    <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    mem_ncs <= 1'b1;
                end
                default: mem_ncs <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_wts_mem_arbiter.sv
// Directed bench for wts_mem_arbiter with hand-computed cycle-by-cycle expectations.
module tb_wts_mem_arbiter;

    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          slot_nreset;
    logic          cpu_req;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_rdata;
    logic          cpu_valid;
    logic          wave_req;
    logic [AW-1:0] wave_address;
    logic          wave_ack;
    logic [7:0]    wave_rdata;
    logic          wave_valid;
    logic          mem_ncs;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_d;

    int total = 0;
    int bad   = 0;

    wts_mem_arbiter #(
        .ADDR_W         (AW),
        .ACCESS_CYCLES  (3),
        .RECOVER_CYCLES (1)
    ) dut (
        .clk          (clk),
        .slot_nreset  (slot_nreset),
        .cpu_req      (cpu_req),
        .cpu_address  (cpu_address),
        .cpu_rdata    (cpu_rdata),
        .cpu_valid    (cpu_valid),
        .wave_req     (wave_req),
        .wave_address (wave_address),
        .wave_ack     (wave_ack),
        .wave_rdata   (wave_rdata),
        .wave_valid   (wave_valid),
        .mem_ncs      (mem_ncs),
        .mem_a        (mem_a),
        .mem_d        (mem_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slot_nreset  = 1'b0;
        cpu_req      = 1'b0;
        cpu_address  = '0;
        wave_req     = 1'b0;
        wave_address = '0;
        mem_d        = 8'h00;
        repeat (2) tick();
        chk("rst_ncs",   32'(mem_ncs), 32'h1);
        chk("rst_a",     32'(mem_a), 32'h0);
        chk("rst_crd",   32'(cpu_rdata), 32'h0);
        chk("rst_pulse", 32'({cpu_valid, wave_ack, wave_valid}), 32'h0);
        slot_nreset = 1'b1;
        repeat (2) tick();

        // CPU read with hold phase
        cpu_req = 1'b1; cpu_address = 21'h02001; mem_d = 8'hA5;
        tick();
        chk("cpu_ncs_low", 32'(mem_ncs), 32'h0);
        chk("cpu_a",       32'(mem_a), 32'h02001);
        chk("cpu_v_e0",    32'(cpu_valid), 32'h0);
        tick(); chk("cpu_v_e1", 32'(cpu_valid), 32'h0);
        tick(); chk("cpu_v_e2", 32'(cpu_valid), 32'h0);
        tick();
        chk("cpu_v_e3",  32'(cpu_valid), 32'h1);
        chk("cpu_rdata", 32'(cpu_rdata), 32'hA5);
        cpu_address = 21'h0F0F0;
        tick();
        chk("hold_v",   32'(cpu_valid), 32'h0);
        chk("hold_ncs", 32'(mem_ncs), 32'h0);
        tick();
        chk("hold_a",   32'(mem_a), 32'h02001);
        cpu_req = 1'b0;
        tick();
        chk("cpu_rel_ncs", 32'(mem_ncs), 32'h1);
        repeat (2) tick();

        // Wave fetch, continuous request
        wave_req = 1'b1; wave_address = 21'h1FFFFF; mem_d = 8'h3C;
        tick();
        chk("wv_ack",   32'(wave_ack), 32'h1);
        chk("wv_a",     32'(mem_a), 32'h1FFFFF);
        chk("wv_ncs",   32'(mem_ncs), 32'h0);
        tick(); chk("wv_ack_e1", 32'(wave_ack), 32'h0);
        tick(); chk("wv_v_e2",   32'(wave_valid), 32'h0);
        tick();
        chk("wv_v_e3",   32'(wave_valid), 32'h1);
        chk("wv_rdata",  32'(wave_rdata), 32'h3C);
        chk("wv_ncs_e3", 32'(mem_ncs), 32'h1);
        tick();
        chk("wv_ack_e4", 32'(wave_ack), 32'h0);
        chk("wv_ncs_e4", 32'(mem_ncs), 32'h1);
        tick();
        chk("wv_ack_e5", 32'(wave_ack), 32'h1);
        wave_req = 1'b0;
        repeat (5) tick();
        chk("wv_idle_ncs", 32'(mem_ncs), 32'h1);

        // Simultaneous requests: CPU first
        cpu_req = 1'b1; cpu_address = 21'h0ABCD;
        wave_req = 1'b1; wave_address = 21'h15555; mem_d = 8'h11;
        tick();
        chk("sim_a",   32'(mem_a), 32'h0ABCD);
        chk("sim_ack", 32'(wave_ack), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sim_noack", 32'(wave_ack), 32'h0);
        end
        wave_address = 21'h12345;
        cpu_req = 1'b0;
        tick();
        chk("sim_rec_ncs", 32'(mem_ncs), 32'h1);
        chk("sim_rec_ack", 32'(wave_ack), 32'h0);
        tick();
        chk("sim_idle_ack", 32'(wave_ack), 32'h0);
        tick();
        chk("sim_ack_late", 32'(wave_ack), 32'h1);
        chk("sim_wv_a",     32'(mem_a), 32'h12345);
        wave_req = 1'b0;
        repeat (3) tick();
        chk("sim_wv_valid", 32'(wave_valid), 32'h1);
        chk("sim_wv_rdata", 32'(wave_rdata), 32'h11);
        repeat (2) tick();

        // CPU request during a wave fetch
        wave_req = 1'b1; wave_address = 21'h00100; mem_d = 8'h5A;
        tick();
        chk("mid_ack", 32'(wave_ack), 32'h1);
        wave_req = 1'b0; cpu_req = 1'b1; cpu_address = 21'h03FFF;
        tick(); chk("mid_a_e1", 32'(mem_a), 32'h00100);
        tick();
        tick();
        chk("mid_wv_valid", 32'(wave_valid), 32'h1);
        chk("mid_wv_rdata", 32'(wave_rdata), 32'h5A);
        tick();
        chk("mid_rec_ncs", 32'(mem_ncs), 32'h1);
        mem_d = 8'h77;
        tick();
        chk("mid_cpu_ncs", 32'(mem_ncs), 32'h0);
        chk("mid_cpu_a",   32'(mem_a), 32'h03FFF);
        repeat (3) tick();
        chk("mid_cpu_v",   32'(cpu_valid), 32'h1);
        chk("mid_cpu_rd",  32'(cpu_rdata), 32'h77);
        cpu_req = 1'b0;
        repeat (3) tick();

        // CPU abort after one access clock
        cpu_req = 1'b1; cpu_address = 21'h01000; mem_d = 8'hEE;
        tick();
        chk("abt_ncs0", 32'(mem_ncs), 32'h0);
        cpu_req = 1'b0;
        tick();
        chk("abt_ncs1", 32'(mem_ncs), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("abt_nov", 32'(cpu_valid), 32'h0);
            tick();
        end
        chk("abt_rdata", 32'(cpu_rdata), 32'h77);

        // Reset in the middle of a wave access
        wave_req = 1'b1; wave_address = 21'h0AAAA; mem_d = 8'h99;
        tick();
        chk("rwv_ack", 32'(wave_ack), 32'h1);
        wave_req = 1'b0;
        tick();
        slot_nreset = 1'b0;
        #1;
        chk("rwv_ncs",   32'(mem_ncs), 32'h1);
        chk("rwv_a",     32'(mem_a), 32'h0);
        chk("rwv_wrd",   32'(wave_rdata), 32'h0);
        chk("rwv_crd",   32'(cpu_rdata), 32'h0);
        repeat (2) tick();
        slot_nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rwv_nov", 32'(wave_valid), 32'h0);
            chk("rwv_ncs_hi", 32'(mem_ncs), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
